// File: rtl/ctrl_pkg.sv
// Shared encodings for the instruction sequencer: states, instruction classes,
// opcodes and program-counter control codes.
package ctrl_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE   = 3'd0;
   localparam state_t ST_FETCH  = 3'd1;
   localparam state_t ST_DECODE = 3'd2;
   localparam state_t ST_EXEC   = 3'd3;
   localparam state_t ST_MEM    = 3'd4;
   localparam state_t ST_WB     = 3'd5;
   localparam state_t ST_HALT   = 3'd6;

   localparam logic [1:0] SM_MEM   = 2'b00;
   localparam logic [1:0] SM_ARITH = 2'b01;
   localparam logic [1:0] SM_LOGIC = 2'b10;
   localparam logic [1:0] SM_FLOW  = 2'b11;

   localparam logic [3:0] OP_LDI = 4'h0;
   localparam logic [3:0] OP_LDM = 4'h1;
   localparam logic [3:0] OP_STM = 4'h2;
   localparam logic [3:0] OP_CMP = 4'h0;
   localparam logic [3:0] OP_ADD = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_JMP = 4'h0;
   localparam logic [3:0] OP_JZ  = 4'h1;
   localparam logic [3:0] OP_JC  = 4'h2;
   localparam logic [3:0] OP_JN  = 4'h3;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [1:0] PC_HOLD = 2'b00;
   localparam logic [1:0] PC_INC  = 2'b01;
   localparam logic [1:0] PC_LOAD = 2'b10;

   localparam int FLAG_Z = 0;
   localparam int FLAG_C = 1;
   localparam int FLAG_N = 2;

endpackage

// File: rtl/ctrl_wait_timer.sv
// Memory-handshake wait counter; expired fires on the cycle whose un-acked
// tick would bring the count to MAX_CNT.
module ctrl_wait_timer #(
   parameter int MAX_CNT = 15,
   parameter int CNT_W   = $clog2(MAX_CNT + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic tick,
   output logic expired
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign expired = tick && (cnt == CNT_W'(MAX_CNT - 1));

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/write-back
// control with memory-handshake timeout and a terminal HALT state.
//
// state  | meaning
// IDLE   | waiting for run
// FETCH  | instruction read in flight, IR loads on mem_ack
// DECODE | pc increment
// EXEC   | ALU op / branch resolution / illegal detection
// MEM    | data read (ldm) or write (stm) in flight
// WB     | register file write
// HALT   | stopped until reset
import ctrl_pkg::*;

module ctrl_sequencer #(
   parameter int OP_W        = 4,
   parameter int SM_W        = 2,
   parameter int FLAG_W      = 3,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic [SM_W-1:0]   sm,
   input  logic [OP_W-1:0]   op,
   input  logic [FLAG_W-1:0] flag_alu,
   input  logic              mem_ack,
   output logic [1:0]        pc_ctr,
   output logic              mem_req,
   output logic              mem_we,
   output logic              reg_we,
   output logic              reg_dst,
   output logic [OP_W-1:0]   alu_ctr,
   output logic              alu_src,
   output logic              mem_to_reg,
   output logic              ir_load,
   output logic              halted,
   output logic              illegal,
   output logic              bus_err
);

   state_t            state, state_nxt;
   logic [SM_W-1:0]   sm_q;
   logic [OP_W-1:0]   op_q;
   logic [FLAG_W-1:0] flag_q;

   logic wait_st, tmr_clr, tmr_tick, tmr_expired;
   logic is_mem, is_arith, is_logic, is_flow;
   logic op_ldi, op_ldm, op_stm, op_cmp, op_addsub, op_jump, op_hlt;
   logic jump_taken, op_defined;

   assign is_mem   = (sm_q == SM_W'(SM_MEM));
   assign is_arith = (sm_q == SM_W'(SM_ARITH));
   assign is_logic = (sm_q == SM_W'(SM_LOGIC));
   assign is_flow  = (sm_q == SM_W'(SM_FLOW));

   assign op_ldi    = is_mem && (op_q == OP_W'(OP_LDI));
   assign op_ldm    = is_mem && (op_q == OP_W'(OP_LDM));
   assign op_stm    = is_mem && (op_q == OP_W'(OP_STM));
   assign op_cmp    = is_arith && (op_q == OP_W'(OP_CMP));
   assign op_addsub = is_arith && ((op_q == OP_W'(OP_ADD)) || (op_q == OP_W'(OP_SUB)));
   assign op_jump   = is_flow && ((op_q == OP_W'(OP_JMP)) || (op_q == OP_W'(OP_JZ)) ||
                                  (op_q == OP_W'(OP_JC))  || (op_q == OP_W'(OP_JN)));
   assign op_hlt    = is_flow && (op_q == OP_W'(OP_HLT));

   assign op_defined = op_ldi || op_ldm || op_stm || op_cmp || op_addsub ||
                       is_logic || op_jump || op_hlt;

   always_comb begin
      jump_taken = 1'b0;
      if (is_flow) begin
         if (op_q == OP_W'(OP_JMP))     jump_taken = 1'b1;
         else if (op_q == OP_W'(OP_JZ)) jump_taken = flag_q[FLAG_Z];
         else if (op_q == OP_W'(OP_JC)) jump_taken = flag_q[FLAG_C];
         else if (op_q == OP_W'(OP_JN)) jump_taken = flag_q[FLAG_N];
      end
   end

   // The counter only runs while a handshake is pending; an ack or any other
   // state holds it at zero, so every FETCH/MEM visit starts from a clean count.
   assign wait_st  = (state == ST_FETCH) || (state == ST_MEM);
   assign tmr_tick = wait_st && !mem_ack;
   assign tmr_clr  = !wait_st || mem_ack;

   ctrl_wait_timer #(.MAX_CNT(MEM_TIMEOUT)) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (tmr_clr),
      .tick    (tmr_tick),
      .expired (tmr_expired)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (run) state_nxt = ST_FETCH;
         ST_FETCH: begin
            if (mem_ack)          state_nxt = ST_DECODE;
            else if (tmr_expired) state_nxt = ST_HALT;
         end
         ST_DECODE: state_nxt = ST_EXEC;
         ST_EXEC: begin
            if (op_ldm || op_stm)                        state_nxt = ST_MEM;
            else if (op_ldi || op_addsub || is_logic)    state_nxt = ST_WB;
            else if (op_hlt)                             state_nxt = ST_HALT;
            else                                         state_nxt = ST_FETCH;
         end
         ST_MEM: begin
            if (mem_ack)          state_nxt = op_ldm ? ST_WB : ST_FETCH;
            else if (tmr_expired) state_nxt = ST_HALT;
         end
         ST_WB:     state_nxt = ST_FETCH;
         ST_HALT:   state_nxt = ST_HALT;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sm_q <= '0;
         op_q <= '0;
      end else if ((state == ST_FETCH) && mem_ack) begin
         sm_q <= sm;
         op_q <= op;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flag_q <= '0;
      end else if ((state == ST_EXEC) && (is_arith || is_logic)) begin
         flag_q <= flag_alu;
      end
   end

   // ir_load and bus_err also look at mem_ack so the IR captures the word and
   // a late ack can still cancel the timeout in the same cycle.
   always_comb begin
      pc_ctr     = PC_HOLD;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      reg_we     = 1'b0;
      reg_dst    = 1'b0;
      alu_ctr    = '0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      ir_load    = 1'b0;
      halted     = 1'b0;
      illegal    = 1'b0;
      bus_err    = 1'b0;
      case (state)
         ST_FETCH: begin
            mem_req = 1'b1;
            ir_load = mem_ack;
            bus_err = tmr_expired;
         end
         ST_DECODE: pc_ctr = PC_INC;
         ST_EXEC: begin
            alu_ctr = op_q;
            alu_src = is_arith || is_logic;
            pc_ctr  = jump_taken ? PC_LOAD : PC_HOLD;
            illegal = !op_defined;
         end
         ST_MEM: begin
            mem_req = 1'b1;
            mem_we  = op_stm;
            bus_err = tmr_expired;
         end
         ST_WB: begin
            reg_we     = 1'b1;
            mem_to_reg = op_ldm;
            reg_dst    = op_ldi;
         end
         ST_HALT: halted = 1'b1;
         default: ;
      endcase
   end

endmodule
